anc_sample_sched: RTL and testbench
===================================

// Module: anc_sample_sched
// PURPOSE
//  Per-sample scheduler for the ANC core. Accepts the merged e/x/a/u sample handshake and sequences the shared tap datapath: FIR MAC sweep, MAC drain, one-cycle output pulse to i2s_tx, then LMS weight-update sweep.
//  Owns the single weight-memory write port and arbitrates it between LMS updates and FPGA bypass weight injection.
// PARAMETERS
//  TAPS       32                 filter length, number of tap addresses swept per phase
//  AW         $clog2(TAPS)       tap address width
//  MAC_LAT    2                  MAC pipeline latency, in drain cycles after the last tap
//  BYP_SHIFT  8                  left shift applied to a bypass weight (0..9)
// PORTS
//  clk              in   1    core clock (the muxed core/scan clock)
//  rst              in   1    synchronous, active-high reset
//  init_done        in   1    init shift-in complete; block is inert while low
//  bypass_mode_sel  in   1    1 = weights come from the FPGA bypass, LMS sweep skipped
//  in_valid         in   1    merged sample valid (vr_merge o_valid)
//  in_ready         out  1    sample accept (to vr_merge i_ready)
//  tap_addr         out  AW   tap index for the coefficient/delay-line read
//  mac_en           out  1    MAC accumulate enable
//  mac_clr          out  1    MAC clear-and-load; asserted with tap 0
//  mac_last         out  1    last tap of the FIR sweep
//  out_valid        out  1    one-cycle pulse: MAC result is valid for i2s_tx
//  lms_en           out  1    LMS update enable for tap_addr
//  lms_wdata        in   16   updated weight from the LMS datapath
//  byp_vld          in   1    bypass weight valid
//  byp_data         in   7    signed bypass weight
//  byp_rdy          out  1    bypass weight accepted
//  w_we             out  1    weight write enable
//  w_addr           out  AW   weight write address
//  w_wdata          out  16   weight write data
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; tap and byp_ptr cleared. Reset mid-sweep aborts the sweep; no partial out_valid is issued.
//  States: IDLE -> FIR -> DRAIN -> OUT -> LMS -> IDLE. When byp_mode_q = 1, OUT goes straight to IDLE.
//  IDLE: in_ready = init_done. A transfer occurs when in_valid & in_ready. At transfer, bypass_mode_sel is latched into byp_mode_q for the whole sample.
//  Let T be the transfer cycle:
//   FIR   cycles T+1 .. T+TAPS. tap_addr counts 0..TAPS-1, mac_en = 1, mac_clr on tap 0, mac_last on tap TAPS-1.
//   DRAIN MAC_LAT cycles. All strobes are low.
//   OUT   1 cycle at T+TAPS+MAC_LAT+1. out_valid = 1.
//   LMS   TAPS cycles. tap_addr counts 0..TAPS-1; lms_en = w_we = 1, w_addr = tap_addr, w_wdata = lms_wdata.
//  in_ready is 0 in every non-IDLE state. Samples are back-pressured, never dropped.
//  Minimum sample period is 2*TAPS+MAC_LAT+2 cycles (TAPS+MAC_LAT+2 with bypass mode).
//  Bypass: byp_rdy = (state==IDLE) & init_done & bypass_mode_sel & ~in_valid. An audio sample has priority in the same cycle.
//   On byp_vld & byp_rdy: w_we = 1 in the same cycle, w_addr = byp_ptr, w_wdata = sign-extended byp_data << BYP_SHIFT.
//   byp_ptr increments and wraps TAPS-1 -> 0. It is cleared whenever bypass_mode_sel = 0.
//  Only one writer drives the weight port per cycle, by construction: LMS writes only in LMS, bypass writes only in IDLE.
//  init_done = 0 gives in_ready = byp_rdy = 0 and the block stays in IDLE.
//  A bypass_mode_sel toggle mid-sample affects only the next sample.
// CONFIGURATION
//  ANC_SCHED_STATS_EN defined:
//   Adds outputs sample_cnt[15:0] and overrun_cnt[15:0], both reset to 0.
//   sample_cnt increments on each in_valid & in_ready transfer and wraps.
//   overrun_cnt increments on each rising edge of in_valid seen while state != IDLE, and saturates at 16'hFFFF.
//  ANC_SCHED_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  anc_sched_pkg holds the state enum (IDLE, FIR, DRAIN, OUT, LMS) and the default TAPS/MAC_LAT/BYP_SHIFT localparams shared with anc_top.
//  Sub-module anc_tap_cnt: AW-bit counter with clear, enable, and a last flag at TAPS-1. It is used by the FIR and LMS sweeps. byp_ptr is a separate register.
// TESTING
//  1. Reset, init_done = 1, single in_valid at cycle 10 (TAPS=32, MAC_LAT=2) -> mac_clr at 11, mac_last at 42, out_valid at 45 only, lms_en 46..77, in_ready back at 78.
//  2. in_valid held high continuously -> transfers exactly every 68 cycles; no two out_valid pulses closer than 68.
//  3. bypass_mode_sel = 1, 40 back-to-back byp_data = 7'h41 -> w_addr 0..31 then 0..7; w_wdata = 16'hC100; lms_en never asserted.
//  4. byp_vld and in_valid both high in IDLE -> sample accepted, byp_rdy = 0 that cycle; bypass accepted on the first IDLE cycle with in_valid low.
//  5. rst asserted during the LMS sweep at tap 5 -> next cycle all outputs 0, state IDLE; no w_we until a new transfer.
//  6. [ANC_SCHED_STATS_EN] 3 samples, in_valid rising twice while busy -> sample_cnt = 3, overrun_cnt = 2.

Source files
------------

// File: rtl/anc_sched_pkg.sv
// Shared definitions for the ANC per-sample scheduler: the sequencing state
// encoding, default datapath sizing, and the bypass weight scaling helper.
package anc_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIR   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_LMS   = 3'd4
    } sched_state_e;

    localparam int ANC_TAPS      = 32;
    localparam int ANC_MAC_LAT   = 2;
    localparam int ANC_BYP_SHIFT = 8;

    // Sign-extend a 7-bit bypass weight to the 16-bit weight format, then scale.
    function automatic logic [15:0] byp_weight(input logic [6:0] data, input int shift);
        logic [15:0] ext;
        ext = {{9{data[6]}}, data};
        return ext << shift;
    endfunction

endpackage

// File: rtl/anc_tap_cnt.sv
// Tap address counter shared by the FIR and LMS sweeps (and reused to time
// the MAC drain). Clear wins over enable; counting wraps TAPS-1 -> 0.
module anc_tap_cnt
    import anc_sched_pkg::*;
#(
    parameter int TAPS = ANC_TAPS,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    assign last = (cnt == LAST_IDX);

    // Tap index register: reset/clear to 0, advance and wrap when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {AW{1'b0}};
        end else if (clr) begin
            cnt <= {AW{1'b0}};
        end else if (en) begin
            cnt <= last ? {AW{1'b0}} : cnt + AW'(1'b1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/anc_sample_sched.sv
// Per-sample scheduler for the ANC core: accepts one merged sample, then runs
// FIR sweep -> MAC drain -> output pulse -> LMS weight sweep on the shared tap
// datapath. Owns the weight-memory write port (LMS updates vs. FPGA bypass).
// Optional statistics counters are built when ANC_SCHED_STATS_EN is defined.
module anc_sample_sched
    import anc_sched_pkg::*;
#(
    parameter int TAPS      = ANC_TAPS,
    parameter int AW        = $clog2(TAPS),
    parameter int MAC_LAT   = ANC_MAC_LAT,
    parameter int BYP_SHIFT = ANC_BYP_SHIFT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_done,
    input  logic          bypass_mode_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] tap_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last,
    output logic          out_valid,
    output logic          lms_en,
    input  logic [15:0]   lms_wdata,
    input  logic          byp_vld,
    input  logic [6:0]    byp_data,
    output logic          byp_rdy,
`ifdef ANC_SCHED_STATS_EN
    output logic [15:0]   sample_cnt,
    output logic [15:0]   overrun_cnt,
`endif
    output logic          w_we,
    output logic [AW-1:0] w_addr,
    output logic [15:0]   w_wdata
);

    localparam logic [AW-1:0] DRAIN_LAST = AW'(MAC_LAT - 1);
    localparam logic [AW-1:0] PTR_LAST   = AW'(TAPS - 1);
    // With no MAC pipeline the result is ready right after the last tap.
    localparam sched_state_e  FIR_EXIT   = (MAC_LAT == 0) ? ST_OUT : ST_DRAIN;

    sched_state_e  state;
    sched_state_e  state_next;
    logic          byp_mode_q;
    logic [AW-1:0] byp_ptr;
    logic [AW-1:0] cnt;
    logic          cnt_last;
    logic          cnt_clr;
    logic          cnt_en;
    logic          xfer;
    logic          byp_ok;
    logic          byp_fire;

    // An audio sample wins over a bypass weight in the same IDLE cycle.
    assign xfer     = (state == ST_IDLE) & init_done & in_valid;
    assign byp_ok   = (state == ST_IDLE) & init_done & bypass_mode_sel & ~in_valid & ~rst;
    assign byp_fire = byp_ok & byp_vld;

    anc_tap_cnt #(
        .TAPS (TAPS),
        .AW   (AW)
    ) u_tap_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bypass mode is frozen per sample at the transfer cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_mode_q <= 1'b0;
        end else if (xfer) begin
            byp_mode_q <= bypass_mode_sel;
        end else begin
            byp_mode_q <= byp_mode_q;
        end
    end

    // Bypass write pointer: cleared outside bypass mode, wraps at TAPS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_ptr <= {AW{1'b0}};
        end else if (!bypass_mode_sel) begin
            byp_ptr <= {AW{1'b0}};
        end else if (byp_fire) begin
            byp_ptr <= (byp_ptr == PTR_LAST) ? {AW{1'b0}} : byp_ptr + AW'(1'b1);
        end else begin
            byp_ptr <= byp_ptr;
        end
    end

    // Next-state sequencing and tap counter control (counter restarts on every state change).
    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_next = ST_FIR;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_FIR: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_next = FIR_EXIT;
                end else begin
                    state_next = ST_FIR;
                end
            end
            ST_DRAIN: begin
                cnt_en = 1'b1;
                if (cnt == DRAIN_LAST) begin
                    state_next = ST_OUT;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (byp_mode_q) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_LMS;
                end
            end
            ST_LMS: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_LMS;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        cnt_clr = (state_next != state);
    end

    // Datapath strobes and weight-port mux; everything held low during reset.
    always_comb begin
        in_ready  = 1'b0;
        byp_rdy   = 1'b0;
        tap_addr  = {AW{1'b0}};
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        mac_last  = 1'b0;
        out_valid = 1'b0;
        lms_en    = 1'b0;
        w_we      = 1'b0;
        w_addr    = {AW{1'b0}};
        w_wdata   = 16'h0000;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready = init_done;
                    byp_rdy  = byp_ok;
                    if (byp_fire) begin
                        w_we    = 1'b1;
                        w_addr  = byp_ptr;
                        w_wdata = byp_weight(byp_data, BYP_SHIFT);
                    end else begin
                        w_we    = 1'b0;
                    end
                end
                ST_FIR: begin
                    tap_addr = cnt;
                    mac_en   = 1'b1;
                    mac_clr  = (cnt == {AW{1'b0}});
                    mac_last = cnt_last;
                end
                ST_DRAIN: begin
                    mac_en = 1'b0;
                end
                ST_OUT: begin
                    out_valid = 1'b1;
                end
                ST_LMS: begin
                    tap_addr = cnt;
                    lms_en   = 1'b1;
                    w_we     = 1'b1;
                    w_addr   = cnt;
                    w_wdata  = lms_wdata;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

`ifdef ANC_SCHED_STATS_EN
    logic in_valid_q;

    // Previous in_valid, for rising-edge detection while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
        end
    end

    // Accepted-sample counter, free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= 16'h0000;
        end else if (xfer) begin
            sample_cnt <= sample_cnt + 16'h0001;
        end else begin
            sample_cnt <= sample_cnt;
        end
    end

    // Samples that showed up while a sweep was running; saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= 16'h0000;
        end else if (in_valid && !in_valid_q && (state != ST_IDLE) && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'h0001;
        end else begin
            overrun_cnt <= overrun_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_anc_sample_sched.sv
// Directed, self-checking bench for anc_sample_sched (TAPS=32, MAC_LAT=2,
// BYP_SHIFT=8). Expected output-pulse cycles and bypass writes are queued when
// stimulus is driven and popped when the DUT produces them.
module tb_anc_sample_sched;

    localparam int TAPS    = 32;
    localparam int AW      = 5;
    localparam int MAC_LAT = 2;
    localparam int OUT_OFS = TAPS + MAC_LAT + 1;
    localparam int PERIOD  = 2 * TAPS + MAC_LAT + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          bypass_mode_sel;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] tap_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          mac_last;
    logic          out_valid;
    logic          lms_en;
    logic [15:0]   lms_wdata;
    logic          byp_vld;
    logic [6:0]    byp_data;
    logic          byp_rdy;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_wdata;
`ifdef ANC_SCHED_STATS_EN
    logic [15:0]   sample_cnt;
    logic [15:0]   overrun_cnt;
`endif

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int last_t = 0;
    int t_a = 0;
    int exp_out[$];
    logic [20:0] exp_w[$];

    anc_sample_sched dut (
        .clk             (clk),
        .rst             (rst),
        .init_done       (init_done),
        .bypass_mode_sel (bypass_mode_sel),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .tap_addr        (tap_addr),
        .mac_en          (mac_en),
        .mac_clr         (mac_clr),
        .mac_last        (mac_last),
        .out_valid       (out_valid),
        .lms_en          (lms_en),
        .lms_wdata       (lms_wdata),
        .byp_vld         (byp_vld),
        .byp_data        (byp_data),
        .byp_rdy         (byp_rdy),
`ifdef ANC_SCHED_STATS_EN
        .sample_cnt      (sample_cnt),
        .overrun_cnt     (overrun_cnt),
`endif
        .w_we            (w_we),
        .w_addr          (w_addr),
        .w_wdata         (w_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    // One expected bypass write in the current IDLE cycle.
    task automatic byp_write(input logic [6:0] d, input logic [AW-1:0] a, input logic [15:0] wd);
        logic [20:0] e;
        byp_data = d;
        exp_w.push_back({a, wd});
        #1;
        chk1("byp_rdy", byp_rdy, 1'b1);
        chk1("byp_we", w_we, 1'b1);
        chk1("byp_lms_en", lms_en, 1'b0);
        e = exp_w.pop_front();
        chk("byp_addr", 32'(w_addr), 32'(e[20:16]));
        chk("byp_wdata", 32'(w_wdata), 32'(e[15:0]));
        step();
    endtask

    // One sample starting in an IDLE cycle; ends at the next IDLE cycle
    // (or right after a reset injected at LMS tap abort_k).
    task automatic run_sample(input logic hold, input logic byp, input int pulse_k, input int abort_k);
        in_valid = 1'b1;
        #1;
        chk1("xfer_ready", in_ready, 1'b1);
        chk1("xfer_byp_rdy", byp_rdy, 1'b0);
        chk1("xfer_w_we", w_we, 1'b0);
        last_t = cyc;
        exp_out.push_back(cyc + OUT_OFS);
        step();
        for (int k = 0; k < TAPS; k++) begin
            in_valid = hold ? 1'b1 : ((k == pulse_k) ? 1'b1 : 1'b0);
            #1;
            chk("fir_tap", 32'(tap_addr), k);
            chk1("fir_mac_en", mac_en, 1'b1);
            chk1("fir_mac_clr", mac_clr, k == 0);
            chk1("fir_mac_last", mac_last, k == TAPS - 1);
            chk1("fir_busy", in_ready, 1'b0);
            chk1("fir_lms_en", lms_en, 1'b0);
            step();
        end
        for (int d = 0; d < MAC_LAT; d++) begin
            #1;
            chk1("drain_mac_en", mac_en, 1'b0);
            chk1("drain_out", out_valid, 1'b0);
            chk1("drain_w_we", w_we, 1'b0);
            chk1("drain_busy", in_ready, 1'b0);
            step();
        end
        #1;
        chk1("out_valid", out_valid, 1'b1);
        chk("out_cycle", cyc, exp_out.pop_front());
        chk1("out_lms_en", lms_en, 1'b0);
        chk1("out_busy", in_ready, 1'b0);
        step();
        if (!byp) begin
            for (int k = 0; k < TAPS; k++) begin
                lms_wdata = 16'($urandom);
                if (k == abort_k) begin
                    rst = 1'b1;
                    #1;
                    chk1("abort_w_we_now", w_we, 1'b0);
                    step();
                    chk1("rst_in_ready", in_ready, 1'b0);
                    chk1("rst_byp_rdy", byp_rdy, 1'b0);
                    chk1("rst_mac_en", mac_en, 1'b0);
                    chk1("rst_mac_clr", mac_clr, 1'b0);
                    chk1("rst_mac_last", mac_last, 1'b0);
                    chk1("rst_out_valid", out_valid, 1'b0);
                    chk1("rst_lms_en", lms_en, 1'b0);
                    chk1("rst_w_we", w_we, 1'b0);
                    chk("rst_tap_addr", 32'(tap_addr), 0);
                    chk("rst_w_addr", 32'(w_addr), 0);
                    chk("rst_w_wdata", 32'(w_wdata), 0);
                    rst = 1'b0;
                    #1;
                    chk1("abort_idle_ready", in_ready, 1'b1);
                    chk1("abort_lms_en", lms_en, 1'b0);
                    return;
                end
                #1;
                chk1("lms_en", lms_en, 1'b1);
                chk1("lms_w_we", w_we, 1'b1);
                chk("lms_tap", 32'(tap_addr), k);
                chk("lms_w_addr", 32'(w_addr), k);
                chk("lms_w_wdata", 32'(w_wdata), 32'(lms_wdata));
                chk1("lms_mac_en", mac_en, 1'b0);
                chk1("lms_busy", in_ready, 1'b0);
                step();
            end
        end
    endtask

    initial begin
        // Reset with every input active: all outputs must stay low.
        rst             = 1'b1;
        init_done       = 1'b1;
        bypass_mode_sel = 1'b1;
        in_valid        = 1'b1;
        byp_vld         = 1'b1;
        byp_data        = 7'h41;
        lms_wdata       = 16'h1234;
        step(); step(); step();
        chk1("reset_in_ready", in_ready, 1'b0);
        chk1("reset_byp_rdy", byp_rdy, 1'b0);
        chk1("reset_w_we", w_we, 1'b0);
        chk1("reset_mac_en", mac_en, 1'b0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_lms_en", lms_en, 1'b0);
        chk("reset_tap_addr", 32'(tap_addr), 0);

        // init_done low: block stays inert.
        rst       = 1'b0;
        init_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("noinit_in_ready", in_ready, 1'b0);
            chk1("noinit_byp_rdy", byp_rdy, 1'b0);
            chk1("noinit_w_we", w_we, 1'b0);
            chk1("noinit_mac_en", mac_en, 1'b0);
            step();
        end
        init_done       = 1'b1;
        in_valid        = 1'b0;
        byp_vld         = 1'b0;
        bypass_mode_sel = 1'b0;
        step(); step(); step();

        // Single sample, full FIR/drain/out/LMS sequence.
        run_sample(1'b0, 1'b0, -1, -1);
        #1;
        chk1("idle_ready_after", in_ready, 1'b1);
        chk1("idle_no_out", out_valid, 1'b0);
        step();

        // in_valid held high: back-to-back transfers at the minimum period.
        run_sample(1'b1, 1'b0, -1, -1);
        t_a = last_t;
        run_sample(1'b1, 1'b0, -1, -1);
        chk("period_1", last_t - t_a, PERIOD);
        t_a = last_t;
        run_sample(1'b0, 1'b0, -1, -1);
        chk("period_2", last_t - t_a, PERIOD);

        // 40 back-to-back bypass weights: pointer wraps after 31.
        bypass_mode_sel = 1'b1;
        byp_vld         = 1'b1;
        for (int i = 0; i < 40; i++) begin
            byp_write(7'h41, 5'(i % TAPS), 16'hC100);
        end

        // Sample and bypass together: sample wins; LMS sweep skipped.
        run_sample(1'b0, 1'b1, -1, -1);
        chk("byp_sample_period_ofs", cyc - last_t, TAPS + MAC_LAT + 2);
        byp_write(7'h41, 5'd8, 16'hC100);
        byp_write(7'h3F, 5'd9, 16'h3F00);
        bypass_mode_sel = 1'b0;
        #1;
        chk1("bypsel_off_rdy", byp_rdy, 1'b0);
        chk1("bypsel_off_we", w_we, 1'b0);
        step();
        bypass_mode_sel = 1'b1;
        byp_write(7'h7F, 5'd0, 16'hFF00);
        byp_vld = 1'b0;
        #1;
        chk1("byp_idle_no_we", w_we, 1'b0);
        bypass_mode_sel = 1'b0;
        step();

        // Reset injected at LMS tap 5.
        run_sample(1'b0, 1'b0, -1, 5);
        step();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("post_rst_w_we", w_we, 1'b0);
            chk1("post_rst_out", out_valid, 1'b0);
            chk1("post_rst_mac_en", mac_en, 1'b0);
            step();
        end

        // Three samples with two in_valid rising edges while busy.
        run_sample(1'b0, 1'b0, 5, -1);
        run_sample(1'b0, 1'b0, 10, -1);
        run_sample(1'b0, 1'b0, -1, -1);
`ifdef ANC_SCHED_STATS_EN
        #1;
        chk("sample_cnt", 32'(sample_cnt), 3);
        chk("overrun_cnt", 32'(overrun_cnt), 2);
`endif
        chk("out_queue_left", exp_out.size(), 0);
        chk("byp_queue_left", exp_w.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
